// File: rtl/wb_select_stage.sv
// Writeback-source select stage: NSRC-way mux, x0 write guard, two-entry skid buffer.
// Define WB_LOAD_EXT_EN to align and sign/zero-extend load data on source LOAD_IDX.
module wb_select_stage #(
  parameter int XLEN     = 32,
  parameter int NSRC     = 6,
  parameter int SEL_W    = 3,
  parameter int LOAD_IDX = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NSRC*XLEN-1:0] in_src,
  input  logic [SEL_W-1:0]     in_sel,
  input  logic [4:0]           in_rd,
  input  logic                 in_we,
  input  logic [2:0]           in_funct3,
  input  logic [1:0]           in_addr_lo,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_data,
  output logic [4:0]           out_rd,
  output logic                 out_we,
  output logic                 out_err
);

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [4:0]      rd;
    logic            we;
    logic            err;
  } entry_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t          state;
  entry_t          main_q, skid_q, cap;
  logic [XLEN-1:0] raw;
  logic            accept, drain;

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

`ifdef WB_LOAD_EXT_EN
  logic [XLEN-1:0] word;
  assign word = raw >> {in_addr_lo, 3'b000};
`else
  logic unused_cfg;
  assign unused_cfg = ^{in_funct3, in_addr_lo, LOAD_IDX[0]};
`endif

  // Unmatched select leaves data at zero and flags the beat.
  always_comb begin
    raw     = '0;
    cap     = '0;
    cap.err = 1'b1;
    for (int k = 0; k < NSRC; k++) begin
      if (in_sel == SEL_W'(k)) begin
        raw     = in_src[k*XLEN +: XLEN];
        cap.err = 1'b0;
      end
    end
    cap.data = raw;
`ifdef WB_LOAD_EXT_EN
    if (in_sel == SEL_W'(LOAD_IDX)) begin
      case (in_funct3)
        3'b000:  cap.data = {{(XLEN-8){word[7]}}, word[7:0]};
        3'b001:  cap.data = {{(XLEN-16){word[15]}}, word[15:0]};
        3'b010:  cap.data = word;
        3'b100:  cap.data = {{(XLEN-8){1'b0}}, word[7:0]};
        3'b101:  cap.data = {{(XLEN-16){1'b0}}, word[15:0]};
        default: cap.data = raw;
      endcase
    end
`endif
    cap.rd = in_rd;
    cap.we = in_we && (in_rd != 5'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      state     <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          main_q    <= cap;
          out_valid <= 1'b1;
          state     <= ONE;
        end
        ONE: begin
          if (accept && !drain) begin
            skid_q   <= cap;
            in_ready <= 1'b0;
            state    <= TWO;
          end else if (accept) begin
            main_q <= cap;
          end else if (drain) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        TWO: if (drain) begin
          main_q   <= skid_q;
          in_ready <= 1'b1;
          state    <= ONE;
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign out_data = main_q.data;
  assign out_rd   = main_q.rd;
  assign out_we   = main_q.we;
  assign out_err  = main_q.err;

endmodule

// File: tb/tb_wb_select_stage.sv
// Scoreboard bench for wb_select_stage: accepted beats queue an expected entry, drained beats pop and compare.
module tb_wb_select_stage;
  localparam int XLEN = 32, NSRC = 6, SEL_W = 3;

  logic                 clk = 1'b0;
  logic                 rst_n, flush, in_valid, in_ready, in_we, out_valid, out_ready, out_we, out_err;
  logic [NSRC*XLEN-1:0] in_src;
  logic [SEL_W-1:0]     in_sel;
  logic [4:0]           in_rd, out_rd;
  logic [2:0]           in_funct3;
  logic [1:0]           in_addr_lo;
  logic [XLEN-1:0]      out_data;
  logic [XLEN-1:0]      srcs [NSRC];

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0, n_fail = 0;

  wb_select_stage #(.XLEN(XLEN), .NSRC(NSRC), .SEL_W(SEL_W), .LOAD_IDX(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_src(in_src), .in_sel(in_sel), .in_rd(in_rd), .in_we(in_we), .in_funct3(in_funct3),
    .in_addr_lo(in_addr_lo), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_we(out_we), .out_err(out_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    in_src = '0;
    for (int k = 0; k < NSRC; k++) in_src[k*XLEN +: XLEN] = srcs[k];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] sel, input logic [4:0] rd, input logic we,
                                 input logic [2:0] f3, input logic [1:0] alo);
    exp_t e;
    logic [31:0] w;
    e.data = 32'h0;
    e.err  = 1'b1;
    if (sel < 3'(NSRC)) begin
      e.data = srcs[sel];
      e.err  = 1'b0;
    end
`ifdef WB_LOAD_EXT_EN
    if (sel == 3'd1) begin
      w = e.data >> (8 * alo);
      case (f3)
        3'b000: e.data = {{24{w[7]}}, w[7:0]};
        3'b001: e.data = {{16{w[15]}}, w[15:0]};
        3'b010: e.data = w;
        3'b100: e.data = {24'h0, w[7:0]};
        3'b101: e.data = {16'h0, w[15:0]};
        default: ;
      endcase
    end
`else
    w = {27'h0, f3, alo};
`endif
    e.rd = rd;
    e.we = we && (rd != 5'd0);
    return e;
  endfunction

  // Monitor samples mid-cycle; inputs change only just after the rising edge.
  always @(negedge clk) begin
    if (!rst_n || flush) exp_q.delete();
    else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", {31'h0, out_valid}, 32'h0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("data", out_data, e.data);
          chk("rd", {27'h0, out_rd}, {27'h0, e.rd});
          chk("we", {31'h0, out_we}, {31'h0, e.we});
          chk("err", {31'h0, out_err}, {31'h0, e.err});
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_sel, in_rd, in_we, in_funct3, in_addr_lo));
    end
  end

  task automatic set_beat(input logic [2:0] sel, input logic [4:0] rd, input logic we,
                          input logic [2:0] f3, input logic [1:0] alo);
    in_sel = sel; in_rd = rd; in_we = we; in_funct3 = f3; in_addr_lo = alo;
  endtask

  // Offer a beat until accepted; returns just after the accepting edge.
  task automatic send(input logic [2:0] sel, input logic [4:0] rd, input logic we,
                      input logic [2:0] f3, input logic [1:0] alo);
    logic acc;
    acc = 1'b0;
    set_beat(sel, rd, we, f3, alo);
    in_valid = 1'b1;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) chk("accept_timeout", 32'h0, 32'h1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    srcs[0] = 32'h0fffff00; srcs[1] = 32'hf0ffff00; srcs[2] = 32'hff0fff00;
    srcs[3] = 32'hffff0f00; srcs[4] = 32'hfffff000; srcs[5] = 32'hffff0000;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_beat(3'd0, 5'd0, 1'b0, 3'd0, 2'd0);
    idle(2);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_rd", {27'h0, out_rd}, 32'h0);
    chk("rst_out_we", {31'h0, out_we}, 32'h0);
    chk("rst_out_err", {31'h0, out_err}, 32'h0);
    rst_n = 1'b1;
    idle(1);

    // Select sweep, one-cycle latency.
    send(3'd0, 5'd3, 1'b1, 3'd0, 2'd0);
    chk("lat_valid", {31'h0, out_valid}, 32'h1);
    chk("lat_data", out_data, 32'h0fffff00);
    send(3'd1, 5'd3, 1'b1, 3'd0, 2'd0);
    send(3'd4, 5'd3, 1'b1, 3'd0, 2'd0);
    send(3'd5, 5'd3, 1'b1, 3'd0, 2'd0);
    chk("sweep_last", out_data, 32'hffff0000);
    send(3'd6, 5'd3, 1'b1, 3'd0, 2'd0);
    chk("oor_err", {31'h0, out_err}, 32'h1);
    send(3'd7, 5'd9, 1'b0, 3'd0, 2'd0);
    send(3'd0, 5'd0, 1'b1, 3'd0, 2'd0);
    chk("x0_we", {31'h0, out_we}, 32'h0);
    chk("x0_valid", {31'h0, out_valid}, 32'h1);
    idle(2);

    // Back-pressure: third beat waits until the skid entry drains.
    out_ready = 1'b0;
    send(3'd2, 5'd4, 1'b1, 3'd0, 2'd0);
    send(3'd3, 5'd5, 1'b1, 3'd0, 2'd0);
    set_beat(3'd5, 5'd6, 1'b1, 3'd0, 2'd0);
    in_valid = 1'b1;
    idle(2);
    chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
    chk("bp_hold_data", out_data, 32'hff0fff00);
    chk("bp_queue", exp_q.size(), 32'd2);
    out_ready = 1'b1;
    send(3'd5, 5'd6, 1'b1, 3'd0, 2'd0);
    idle(4);
    chk("bp_drained", exp_q.size(), 32'd0);

    // Flush in TWO with a beat offered: everything discarded.
    out_ready = 1'b0;
    send(3'd1, 5'd7, 1'b1, 3'd0, 2'd0);
    send(3'd2, 5'd8, 1'b1, 3'd0, 2'd0);
    set_beat(3'd4, 5'd9, 1'b1, 3'd0, 2'd0);
    in_valid = 1'b1; flush = 1'b1;
    idle(1);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    chk("flush_valid", {31'h0, out_valid}, 32'h0);
    chk("flush_ready", {31'h0, in_ready}, 32'h1);
    idle(3);

`ifdef WB_LOAD_EXT_EN
    srcs[1] = 32'h80F07F01;
    send(3'd1, 5'd10, 1'b1, 3'b000, 2'd2);
    chk("lb", out_data, 32'hFFFFFFF0);
    send(3'd1, 5'd10, 1'b1, 3'b100, 2'd2);
    chk("lbu", out_data, 32'h000000F0);
    send(3'd1, 5'd10, 1'b1, 3'b001, 2'd2);
    chk("lh", out_data, 32'hFFFF80F0);
    send(3'd1, 5'd10, 1'b1, 3'b101, 2'd2);
    chk("lhu", out_data, 32'h000080F0);
    send(3'd1, 5'd10, 1'b1, 3'b111, 2'd2);
    chk("ld_raw", out_data, 32'h80F07F01);
    send(3'd0, 5'd10, 1'b1, 3'b000, 2'd2);
    chk("ld_other_src", out_data, 32'h0fffff00);
    idle(2);
`endif

    // Reset in TWO.
    out_ready = 1'b0;
    send(3'd4, 5'd11, 1'b1, 3'd0, 2'd0);
    send(3'd5, 5'd12, 1'b1, 3'd0, 2'd0);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1; out_ready = 1'b1;
    chk("mid_rst_valid", {31'h0, out_valid}, 32'h0);
    chk("mid_rst_data", out_data, 32'h0);
    chk("mid_rst_ready", {31'h0, in_ready}, 32'h1);
    idle(3);
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/wb_select_stage.md
# wb_select_stage

Parametrised writeback-source select stage for the RV32I core. It sits between the execute/memory results and the register file write port. It picks one of `NSRC` result sources, can optionally align and extend load data, suppresses writes to x0, and registers the result behind a two-entry valid/ready skid buffer. This generalises the single-cycle writeback mux into a pipelinable, back-pressurable stage.

## Interface
- `XLEN`, 32, datapath width
- `NSRC`, 6, number of result sources (2..8)
- `SEL_W`, 3, select width; requires 2^SEL_W >= NSRC
- `LOAD_IDX`, 1, source index carrying raw memory read data
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset; one clock; reset is synchronous and active-low
- `flush`  in  1  discard all buffered entries
- `in_valid`  in  1  input beat valid
- `in_ready`  out  1  stage can accept a beat
- `in_src`  in  NSRC*XLEN  sources; source k occupies bits [k*XLEN +: XLEN]
- `in_sel`  in  SEL_W  source index
- `in_rd`  in  5  destination register
- `in_we`  in  1  register write request
- `in_funct3`  in  3  load type (used only with `WB_LOAD_EXT_EN`)
- `in_addr_lo`  in  2  load byte offset (used only with `WB_LOAD_EXT_EN`)
- `out_valid`  out  1  writeback beat valid
- `out_ready`  in  1  consumer accepts beat
- `out_data`  out  XLEN  selected, optionally extended, data
- `out_rd`  out  5  destination register
- `out_we`  out  1  effective write enable
- `out_err`  out  1  beat carried an out-of-range select

## Operation
- Select: `in_sel` < NSRC gives source `in_sel`. `in_sel` >= NSRC gives data 0 and `err`=1 for that beat.
- x0 guard: effective `we` = `in_we` && (`in_rd` != 0). It is computed at capture and stored with the beat.
- Buffer holds a main entry (drives outputs) and a skid entry. State machine:
  - EMPTY: main and skid free.
  - ONE: main holds a beat.
  - TWO: main and skid both hold beats.
- `in_ready` = (state != TWO). It is a registered function of state, not combinational from `out_ready`.
- Accept = `in_valid` && `in_ready`. Drain = `out_valid` && `out_ready`.
- Transitions:
  - EMPTY: accept → ONE (beat into main).
  - ONE: accept with no drain → TWO (beat into skid). Accept with drain → ONE (new beat into main). Drain only → EMPTY.
  - TWO: drain → ONE (skid moves to main).
- Ordering is strictly FIFO. No beat is dropped or duplicated.
- `flush` → EMPTY at the next edge. It wins over a simultaneous accept and a simultaneous drain; the accepted beat is discarded.
- Data, rd, we and err of an entry are held stable while `out_valid`=1 and `out_ready`=0.

## Timing
- Reset values: state EMPTY, `out_valid`=0, `in_ready`=1, `out_data`=0, `out_rd`=0, `out_we`=0, `out_err`=0.
- Reset asserted mid-operation discards all entries at that edge, with the same values as above.
- Latency: a beat accepted at edge N appears on outputs after edge N (one cycle) when main is free or draining.
- Throughput: one beat per cycle with `out_ready` held at 1.
- After a stall, `in_ready` falls one cycle after the skid entry fills. It rises the cycle after a drain from TWO.
- `out_we` and `out_err` are meaningful only while `out_valid`=1.

## Configuration
- `WB_LOAD_EXT_EN` defined: when `in_sel`==LOAD_IDX, the word is shifted right by 8*`in_addr_lo`, then processed per `in_funct3`:
  - 000 LB: sign-extend byte
  - 001 LH: sign-extend half
  - 010 LW: full word
  - 100 LBU: zero-extend byte
  - 101 LHU: zero-extend half
  - any other value: unshifted raw word
- Other sources always pass through raw.
- `WB_LOAD_EXT_EN` undefined: all sources pass through raw. `in_funct3` and `in_addr_lo` are ignored. No extension logic is synthesised.

## Test plan
- Reset then select sweep: sources 0x0fffff00, 0xf0ffff00, 0xff0fff00, 0xffff0f00, 0xfffff000, 0xffff0000; sel 0,1,4,5 with rd=3, we=1, out_ready=1 → one cycle later out_data 0x0fffff00, 0xf0ffff00, 0xfffff000, 0xffff0000; out_we=1.
- Out-of-range and x0: sel=6 → out_data=0, out_err=1. Then sel=0 with rd=0, we=1 → out_we=0, out_valid=1.
- Back-pressure: out_ready=0 with 3 beats offered back-to-back → two accepted and in_ready=0. Release out_ready → the beats emerge in order and the third beat is accepted afterwards, with no loss.
- Flush in TWO with in_valid=1 → next cycle out_valid=0, in_ready=1, and the offered beat never appears.
- With `WB_LOAD_EXT_EN`: sel=1, src1=0x80F0_7F01, addr_lo=2 → funct3=000 gives 0xFFFFFFF0, 100 gives 0x000000F0, 001 gives 0xFFFF80F0, 101 gives 0x000080F0.
- Reset mid-stream in state TWO → next cycle out_valid=0, out_data=0, in_ready=1.
